retire_stage: RTL

- In-order commit stage directly downstream of the ROB.
- Each cycle it inspects up to N oldest ROB entries and tells the ROB how many to clear.
- Maintains the retirement (architectural) map table and returns superseded physical registers to the free list.
- Signals branch-mispredict recovery and a program halt.

---
 rtl/retire_stage_if.sv | 42 ++++
 rtl/retire_stage.sv | 118 +++++++++++
 2 files changed

// File: rtl/retire_stage_if.sv
// ============================================================================
// retire_stage_if : ROB-head inputs and commit outputs of retire_stage. rev 1.0
// ============================================================================
`default_nettype none

interface retire_stage_if #(
  parameter int N               = 3,
  parameter int ARCH_REGS       = 32,
  parameter int PHYS_REG_BITS   = 6,
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
);
  logic [NUM_SCALAR_BITS-1:0]         rob_outputs_valid;
  logic [N-1:0]                       rob_complete;
  logic [N-1:0]                       rob_has_dest;
  logic [N*5-1:0]                     rob_arch_dest;
  logic [N*PHYS_REG_BITS-1:0]         rob_phys_dest;
  logic [N-1:0]                       rob_mispredict;
  logic [N-1:0]                       rob_halt;
  logic [NUM_SCALAR_BITS-1:0]         num_retiring;
  logic [N-1:0]                       free_valid;
  logic [N*PHYS_REG_BITS-1:0]         free_regs;
  logic                               mispredict_valid;
  logic [ARCH_REGS*PHYS_REG_BITS-1:0] arch_map_out;
  logic                               halted;
  logic [63:0]                        retired_count;

  modport master (
    output rob_outputs_valid, rob_complete, rob_has_dest, rob_arch_dest,
           rob_phys_dest, rob_mispredict, rob_halt,
    input  num_retiring, free_valid, free_regs, mispredict_valid,
           arch_map_out, halted, retired_count
  );

  modport slave (
    input  rob_outputs_valid, rob_complete, rob_has_dest, rob_arch_dest,
           rob_phys_dest, rob_mispredict, rob_halt,
    output num_retiring, free_valid, free_regs, mispredict_valid,
           arch_map_out, halted, retired_count
  );
endinterface

`default_nettype wire

// File: rtl/retire_stage.sv
// ============================================================================
// retire_stage : in-order commit, retirement map and register freeing. rev 1.0
// ============================================================================
`default_nettype none

module retire_stage #(
  parameter int N               = 3,
  parameter int ARCH_REGS       = 32,
  parameter int PHYS_REG_BITS   = 6,
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  retire_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [PHYS_REG_BITS-1:0]   arch_map_q [ARCH_REGS];
  logic [PHYS_REG_BITS-1:0]   arch_map_d [ARCH_REGS];
  logic                       halted_q;
  logic [63:0]                retired_count_q;

  logic [NUM_SCALAR_BITS-1:0] retire_cnt;
  logic [N-1:0]               free_valid;
  logic [N*PHYS_REG_BITS-1:0] free_regs;
  logic                       mispredict_retire;
  logic                       halt_retire;
  logic                       stop_scan;
  logic [4:0]                 arch;
  logic [PHYS_REG_BITS-1:0]   phys;

  always_comb begin
    arch_map_d        = arch_map_q;
    state_d           = state_q;
    retire_cnt        = '0;
    free_valid        = '0;
    free_regs         = '0;
    mispredict_retire = 1'b0;
    halt_retire       = 1'b0;
    stop_scan         = 1'b0;
    arch              = '0;
    phys              = '0;
    case (state_q)
      S_RUN: begin
        if (!reset) begin
          for (int i = 0; i < N; i++) begin
            arch = bus.rob_arch_dest[i*5 +: 5];
            phys = bus.rob_phys_dest[i*PHYS_REG_BITS +: PHYS_REG_BITS];
            if (!stop_scan) begin
              if ((i < int'(bus.rob_outputs_valid)) && bus.rob_complete[i]) begin
                retire_cnt = retire_cnt + NUM_SCALAR_BITS'(1);
                // Reading arch_map_d chains older same-cycle writes into the freed reg.
                if (bus.rob_has_dest[i] && (arch != 5'd0)) begin
                  free_valid[i]                                   = 1'b1;
                  free_regs[i*PHYS_REG_BITS +: PHYS_REG_BITS]     = arch_map_d[arch];
                  arch_map_d[arch]                                = phys;
                end
                if (bus.rob_mispredict[i]) begin
                  mispredict_retire = 1'b1;
                  stop_scan         = 1'b1;
                end
                if (bus.rob_halt[i]) begin
                  halt_retire = 1'b1;
                  stop_scan   = 1'b1;
                end
              end else begin
                stop_scan = 1'b1;
              end
            end
          end
          if (halt_retire) begin
            state_d = S_HALTED;
          end else if (mispredict_retire) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_RUN;
      halted_q        <= 1'b0;
      retired_count_q <= '0;
      for (int r = 0; r < ARCH_REGS; r++) begin
        arch_map_q[r] <= PHYS_REG_BITS'(r);
      end
    end else begin
      state_q         <= state_d;
      halted_q        <= halted_q | halt_retire;
      retired_count_q <= retired_count_q + 64'(retire_cnt);
      arch_map_q      <= arch_map_d;
    end
  end

  assign bus.num_retiring     = retire_cnt;
  assign bus.free_valid       = free_valid;
  assign bus.free_regs        = free_regs;
  assign bus.mispredict_valid = mispredict_retire;
  assign bus.halted           = halted_q;
  assign bus.retired_count    = retired_count_q;

  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_map_out
    assign bus.arch_map_out[g*PHYS_REG_BITS +: PHYS_REG_BITS] = arch_map_q[g];
  end

endmodule

`default_nettype wire
